alu_exec_unit: RTL

Parametrised execute-stage ALU for the MIPS core, successor to the combinational ALU-control decoder. Decodes the 2-bit ALU opcode plus R-type funct field, executes single-cycle integer ops with a registered result, and runs `mult`/`multu` on an iterative shift-add multiplier into internal HI/LO registers. Sits between ID/EX and EX/MEM; stalls issue through `in_ready` while a multiply is in flight.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_exec_unit_if.sv | 28 ++
 rtl/mul_seq.sv | 95 +++++++++
 rtl/alu_exec_unit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: alu_op codes, R-type funct
// codes and the multiplier sequencing states.
package alu_pkg;

    localparam logic [1:0] ALU_OP_ADD     = 2'b00;
    localparam logic [1:0] ALU_OP_SUB     = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE   = 2'b10;
    localparam logic [1:0] ALU_OP_ILLEGAL = 2'b11;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between ID/EX and the execute ALU.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             bad_op;

    modport master (
        output in_valid, alu_op, funct, shamt, a, b,
        input  in_ready, out_valid, result, zero, overflow, bad_op
    );

    modport slave (
        input  in_valid, alu_op, funct, shamt, a, b,
        output in_ready, out_valid, result, zero, overflow, bad_op
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle over
// WIDTH cycles, then a fix-up cycle that applies the sign of a signed product.
module mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mag_a, mag_b;

    // Signed multiply works on magnitudes; the most-negative value maps to
    // itself, which is the correct magnitude when read as unsigned.
    always_comb begin
        mag_a = (is_signed && op_a[WIDTH-1]) ? ('0 - op_a) : op_a;
        mag_b = (is_signed && op_b[WIDTH-1]) ? ('0 - op_b) : op_b;
    end

    // Sequencer: load on start, add/shift each MUL cycle, one FIX cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_MUL;
                    cnt_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    acc_d    = '0;
                    neg_d    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                end
            end
            ST_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                    cnt_d   = '0;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any multiply in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_FIX);
    assign product = neg_q ? ('0 - acc_q) : acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes alu_op/funct, registers single-cycle results,
// and owns HI/LO, which the sequential multiplier fills for mult/multu.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    alu_exec_unit_if.slave  bus
);
    logic               accept, mul_start, mul_signed, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   sum, diff, op_result;
    logic               add_ovf, sub_ovf, op_ovf, op_bad, op_is_mul;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               overflow_q, overflow_d;
    logic               bad_op_q, bad_op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    assign bus.in_ready = ~mul_busy;
    assign accept       = bus.in_valid & bus.in_ready;
    assign mul_start    = accept & op_is_mul;

    // Shared adder/subtractor and their signed-overflow detection.
    always_comb begin
        sum     = bus.a + bus.b;
        diff    = bus.a - bus.b;
        add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    end

    // Operation decode and single-cycle datapath; shifts operate on rt (b).
    always_comb begin
        op_result  = '0;
        op_ovf     = 1'b0;
        op_bad     = 1'b0;
        op_is_mul  = 1'b0;
        mul_signed = 1'b0;
        unique case (bus.alu_op)
            ALU_OP_ADD: begin op_result = sum;  op_ovf = add_ovf; end
            ALU_OP_SUB: begin op_result = diff; op_ovf = sub_ovf; end
            ALU_OP_RTYPE: begin
                case (bus.funct)
                    FN_ADD:   begin op_result = sum;  op_ovf = add_ovf; end
                    FN_ADDU:  op_result = sum;
                    FN_SUB:   begin op_result = diff; op_ovf = sub_ovf; end
                    FN_SUBU:  op_result = diff;
                    FN_AND:   op_result = bus.a & bus.b;
                    FN_OR:    op_result = bus.a | bus.b;
                    FN_XOR:   op_result = bus.a ^ bus.b;
                    FN_NOR:   op_result = ~(bus.a | bus.b);
                    FN_SLT:   op_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                    FN_SLTU:  op_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
                    FN_SLL:   op_result = bus.b << bus.shamt;
                    FN_SRL:   op_result = bus.b >> bus.shamt;
                    FN_SRA:   op_result = $signed(bus.b) >>> bus.shamt;
                    FN_MFHI:  op_result = hi_q;
                    FN_MFLO:  op_result = lo_q;
                    FN_MULT:  begin op_is_mul = 1'b1; mul_signed = 1'b1; end
                    FN_MULTU: op_is_mul = 1'b1;
                    default:  op_bad = 1'b1;
                endcase
            end
            ALU_OP_ILLEGAL: op_bad = 1'b1;
            default:        op_bad = 1'b1;
        endcase
    end

    // Output and HI/LO next-state: results pulse for one cycle per accepted
    // single-cycle op; multiplies report only through HI/LO.
    always_comb begin
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        bad_op_d    = bad_op_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        if (accept && !op_is_mul) begin
            out_valid_d = 1'b1;
            result_d    = op_result;
            zero_d      = (op_result == '0);
            overflow_d  = op_ovf;
            bad_op_d    = op_bad;
        end
        if (mul_done) begin
            hi_d = mul_product[2*WIDTH-1:WIDTH];
            lo_d = mul_product[WIDTH-1:0];
        end
    end

    // Output and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
            bad_op_q    <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            bad_op_q    <= bad_op_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.bad_op    = bad_op_q;

    mul_seq #(.WIDTH(WIDTH)) u_mul_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .is_signed (mul_signed),
        .op_a      (bus.a),
        .op_b      (bus.b),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product)
    );

endmodule
